issue_select: RTL

- Select stage of the backend scheduler; consumes the per-row `request_vector` produced by the wakeup stage.
- Each cycle, for each FU, grants at most one requesting row using a round-robin policy.
- Returns the granted row to the wakeup stage as a free, so the entry goes back to the free-entry queue.
- After the granted instruction's latency, broadcasts its tag as a dependency-matrix clear line so dependents wake up.
- Each FU is non-pipelined: one outstanding operation per FU.

---
 rtl/issue_select.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/issue_select.sv
// -----------------------------------------------------------------------------
// issue_select
//   Select stage of the backend scheduler. Each cycle, every functional unit
//   picks at most one ready row assigned to it, using round-robin arbitration.
//   A pick becomes a one-cycle registered grant. The same grant is returned to
//   the wakeup stage as a free request. Once the instruction's latency has
//   elapsed, the row's tag is broadcast on the dependency-matrix clear lines.
//   Every FU is non-pipelined, so it holds at most one operation in flight.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   request_vector  per-row ready-to-issue request from the wakeup stage
//   row_fu          FU id of row r at [r*FU_W +: FU_W]
//   row_latency     execute latency of row r at [r*LAT_W +: LAT_W]
//   alloc_en/_row   dispatch (re)allocating a row; re-arms it for issue
//   flush           synchronous pipeline flush
//   grant_valid     FU f issues this cycle (one-cycle pulse)
//   grant_row       row issued to FU f at [f*ROW_W +: ROW_W]
//   free_en         free request to the wakeup stage (mirrors grant_valid)
//   free_row_index  row to free (mirrors grant_row)
//   clear_en        at least one clear line is active this cycle
//   clear_lines     bit f*NUM_ROWS+r: result of FU f, row r now available
//   fu_busy         FU f has an operation in flight
// -----------------------------------------------------------------------------
module issue_select #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS  = 4,
  parameter int LAT_W    = 8,
  localparam int ROW_W   = $clog2(NUM_ROWS),
  localparam int FU_W    = $clog2(NUM_FUS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_ROWS-1:0]         request_vector,
  input  logic [NUM_ROWS*FU_W-1:0]    row_fu,
  input  logic [NUM_ROWS*LAT_W-1:0]   row_latency,
  input  logic                        alloc_en,
  input  logic [ROW_W-1:0]            alloc_row,
  input  logic                        flush,
  output logic [NUM_FUS-1:0]          grant_valid,
  output logic [NUM_FUS*ROW_W-1:0]    grant_row,
  output logic [NUM_FUS-1:0]          free_en,
  output logic [NUM_FUS*ROW_W-1:0]    free_row_index,
  output logic                        clear_en,
  output logic [NUM_ROWS*NUM_FUS-1:0] clear_lines,
  output logic [NUM_FUS-1:0]          fu_busy
);

  typedef enum logic {
    FU_IDLE = 1'b0,
    FU_BUSY = 1'b1
  } fu_state_e;

  // Sequential state
  fu_state_e                          fu_state_q [NUM_FUS];
  fu_state_e                          fu_state_d [NUM_FUS];
  logic [NUM_FUS-1:0][LAT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_FUS-1:0][ROW_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_FUS-1:0][ROW_W-1:0]      tag_row_q, tag_row_d;
  logic [NUM_ROWS-1:0]                issued_mask_q, issued_mask_d;
  logic [NUM_FUS-1:0]                 grant_valid_q, grant_valid_d;
  logic [NUM_FUS*ROW_W-1:0]           grant_row_q, grant_row_d;
  logic                               clear_en_q, clear_en_d;
  logic [NUM_ROWS*NUM_FUS-1:0]        clear_lines_q, clear_lines_d;

  // Combinational selection
  logic [NUM_FUS-1:0]                 fu_ready_s;
  logic [NUM_FUS-1:0][NUM_ROWS-1:0]   elig_s;
  logic [NUM_FUS-1:0]                 sel_valid_s;
  logic [NUM_FUS-1:0][ROW_W-1:0]      sel_row_s;
  logic [NUM_FUS-1:0][LAT_W-1:0]      sel_lat_s;

  // Row eligibility per FU. An FU is ready again while its last cycle
  // (counter = 1) is in progress, which allows back-to-back issue.
  always_comb begin
    for (int f = 0; f < NUM_FUS; f++) begin
      fu_ready_s[f] = (cnt_q[f] <= LAT_W'(1));
      for (int r = 0; r < NUM_ROWS; r++) begin
        elig_s[f][r] = request_vector[r] & ~issued_mask_q[r] & ~flush & fu_ready_s[f]
                     & (row_fu[r*FU_W +: FU_W] == FU_W'(f));
      end
    end
  end

  // Round-robin pick. The scan runs from the farthest candidate down to rr_ptr,
  // so the candidate nearest rr_ptr (modulo NUM_ROWS) is the last one written.
  always_comb begin
    for (int f = 0; f < NUM_FUS; f++) begin
      sel_valid_s[f] = 1'b0;
      sel_row_s[f]   = '0;
      for (int k = NUM_ROWS - 1; k >= 0; k--) begin
        if (elig_s[f][ROW_W'(int'(rr_ptr_q[f]) + k)]) begin
          sel_valid_s[f] = 1'b1;
          sel_row_s[f]   = ROW_W'(int'(rr_ptr_q[f]) + k);
        end else begin
          sel_valid_s[f] = sel_valid_s[f];
        end
      end
      sel_lat_s[f] = row_latency[int'(sel_row_s[f])*LAT_W +: LAT_W];
    end
  end

  // Next-state logic: grants, per-FU countdown FSM, clear broadcast, issued mask.
  always_comb begin
    grant_valid_d = sel_valid_s;
    grant_row_d   = '0;
    clear_lines_d = '0;
    issued_mask_d = issued_mask_q;
    for (int f = 0; f < NUM_FUS; f++) begin
      grant_row_d[f*ROW_W +: ROW_W] = sel_row_s[f];
      rr_ptr_d[f]  = sel_valid_s[f] ? (sel_row_s[f] + ROW_W'(1)) : rr_ptr_q[f];
      tag_row_d[f] = sel_valid_s[f] ? sel_row_s[f] : tag_row_q[f];

      // The clear fires on the 1->0 step of the counter and uses the old tag.
      // A back-to-back grant reloads the tag on the same edge.
      clear_lines_d[f*NUM_ROWS + int'(tag_row_q[f])] = ~flush & (cnt_q[f] == LAT_W'(1));

      issued_mask_d[sel_row_s[f]] = issued_mask_d[sel_row_s[f]] | sel_valid_s[f];

      if (flush) begin
        cnt_d[f] = '0;
      end else if (sel_valid_s[f]) begin
        // A latency of zero is treated as one cycle.
        cnt_d[f] = (sel_lat_s[f] == '0) ? LAT_W'(1) : sel_lat_s[f];
      end else begin
        case (fu_state_q[f])
          FU_BUSY: cnt_d[f] = cnt_q[f] - LAT_W'(1);
          FU_IDLE: cnt_d[f] = '0;
          default: cnt_d[f] = '0;
        endcase
      end
      fu_state_d[f] = (cnt_d[f] != '0) ? FU_BUSY : FU_IDLE;
    end
    // Allocation is applied after the grant, so it wins on the same row.
    issued_mask_d[alloc_row] = issued_mask_d[alloc_row] & ~alloc_en;
    issued_mask_d = flush ? '0 : issued_mask_d;
    clear_en_d    = |clear_lines_d;
  end

  // State and output registers. rr_ptr survives flush because it is only
  // written on a grant, and flush suppresses all grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < NUM_FUS; f++) begin
        fu_state_q[f] <= FU_IDLE;
      end
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      tag_row_q     <= '0;
      issued_mask_q <= '0;
      grant_valid_q <= '0;
      grant_row_q   <= '0;
      clear_en_q    <= 1'b0;
      clear_lines_q <= '0;
    end else begin
      for (int f = 0; f < NUM_FUS; f++) begin
        fu_state_q[f] <= fu_state_d[f];
      end
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      tag_row_q     <= tag_row_d;
      issued_mask_q <= issued_mask_d;
      grant_valid_q <= grant_valid_d;
      grant_row_q   <= grant_row_d;
      clear_en_q    <= clear_en_d;
      clear_lines_q <= clear_lines_d;
    end
  end

  // Busy flag decoded from the registered per-FU state.
  always_comb begin
    for (int f = 0; f < NUM_FUS; f++) begin
      fu_busy[f] = (fu_state_q[f] == FU_BUSY);
    end
  end

  assign grant_valid    = grant_valid_q;
  assign grant_row      = grant_row_q;
  assign free_en        = grant_valid_q;
  assign free_row_index = grant_row_q;
  assign clear_en       = clear_en_q;
  assign clear_lines    = clear_lines_q;

endmodule
